// File: rtl/ce_task_scheduler_pkg.sv
// Shared types and helpers for the clock-enable driven round-robin task scheduler.
package ce_task_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LATCH     = 2'd1,
    ST_START     = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_t;

  function automatic int grant_width(input int num_tasks);
    return (num_tasks > 1) ? $clog2(num_tasks) : 1;
  endfunction

endpackage

// File: rtl/clock_enable_divider.sv
// Divides an incoming clock-enable stream: one registered output pulse per
// par_ce_divisor input enables; synchronous active-high reset restarts the count.
module clock_enable_divider #(
  parameter int par_ce_divisor = 1000
) (
  input  logic i_clk_mhz,
  input  logic i_rst_mhz,
  input  logic i_ce_mhz,
  output logic o_ce_div
);

  localparam int CNT_W = (par_ce_divisor > 1) ? $clog2(par_ce_divisor) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(par_ce_divisor - 1);

  logic [CNT_W-1:0] ce_count;

  always_ff @(posedge i_clk_mhz) begin
    if (i_rst_mhz) begin
      ce_count <= '0;
      o_ce_div <= 1'b0;
    end else begin
      o_ce_div <= 1'b0;
      if (i_ce_mhz) begin
        if (ce_count == CNT_LAST) begin
          ce_count <= '0;
          o_ce_div <= 1'b1;
        end else begin
          ce_count <= ce_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ce_task_scheduler.sv
// Round-robin task scheduler: each schedule tick snapshots the requests, then
// grants them one at a time with a start pulse, waiting for done or a tick-counted timeout.
module ce_task_scheduler
  import ce_task_scheduler_pkg::*;
#(
  parameter int par_num_tasks     = 3,
  parameter int par_tick_divisor  = 1000,
  parameter int par_timeout_ticks = 4
) (
  input  logic                                     i_clk_mhz,
  input  logic                                     i_rstn_mhz,
  input  logic                                     i_ce_mhz,
  input  logic [par_num_tasks-1:0]                 i_req,
  input  logic [par_num_tasks-1:0]                 i_done,
  input  logic                                     i_clr_overrun,
  output logic [par_num_tasks-1:0]                 o_start,
  output logic [grant_width(par_num_tasks)-1:0]    o_grant_idx,
  output logic                                     o_busy,
  output logic                                     o_timeout,
  output logic                                     o_overrun
);

  localparam int IDX_W = grant_width(par_num_tasks);
  localparam int TO_W  = $clog2(par_timeout_ticks + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(par_timeout_ticks - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(par_num_tasks - 1);

  sched_state_t             state, state_nxt;
  logic [par_num_tasks-1:0] pending, pending_nxt;
  logic [IDX_W-1:0]         ptr, ptr_nxt;
  logic [IDX_W-1:0]         grant, grant_nxt;
  logic [IDX_W-1:0]         grant_inc;
  logic [TO_W-1:0]          to_count, to_count_nxt;
  logic [par_num_tasks-1:0] start_nxt;
  logic                     timeout_nxt;
  logic                     overrun_nxt;
  logic                     tick;
  logic                     sel_found;
  logic [IDX_W-1:0]         sel_idx;

  clock_enable_divider #(
    .par_ce_divisor (par_tick_divisor)
  ) u_tick_div (
    .i_clk_mhz (i_clk_mhz),
    .i_rst_mhz (~i_rstn_mhz),
    .i_ce_mhz  (i_ce_mhz),
    .o_ce_div  (tick)
  );

  // First pending task at or after the round-robin pointer, wrapping around.
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = 0;
    for (int i = 0; i < par_num_tasks; i++) begin
      cand = (int'(ptr) + i) % par_num_tasks;
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant_inc = (grant == IDX_LAST) ? '0 : grant + 1'b1;

  always_comb begin
    state_nxt    = state;
    pending_nxt  = pending;
    ptr_nxt      = ptr;
    grant_nxt    = grant;
    to_count_nxt = to_count;
    start_nxt    = '0;
    timeout_nxt  = 1'b0;
    overrun_nxt  = (o_overrun & ~i_clr_overrun) | (tick & (state != ST_IDLE));

    case (state)
      ST_IDLE: begin
        if (tick) begin
          pending_nxt = i_req;
          state_nxt   = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (!sel_found) begin
          state_nxt = ST_IDLE;
        end else begin
          grant_nxt = sel_idx;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        start_nxt[grant] = 1'b1;
        to_count_nxt     = '0;
        state_nxt        = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done in the same clock as the expiring tick takes priority.
        if (i_done[grant]) begin
          pending_nxt[grant] = 1'b0;
          ptr_nxt            = grant_inc;
          state_nxt          = ST_LATCH;
        end else if (tick) begin
          if (to_count == TO_LAST) begin
            timeout_nxt        = 1'b1;
            pending_nxt[grant] = 1'b0;
            ptr_nxt            = grant_inc;
            state_nxt          = ST_LATCH;
          end else begin
            to_count_nxt = to_count + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_mhz) begin
    if (!i_rstn_mhz) begin
      state     <= ST_IDLE;
      pending   <= '0;
      ptr       <= '0;
      grant     <= '0;
      to_count  <= '0;
      o_start   <= '0;
      o_timeout <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      to_count  <= to_count_nxt;
      o_start   <= start_nxt;
      o_timeout <= timeout_nxt;
      o_overrun <= overrun_nxt;
    end
  end

  assign o_grant_idx = grant;
  assign o_busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_ce_task_scheduler.sv
// Scoreboard bench: stimulus pushes expected grants/timeouts, a monitor pops and
// compares them whenever the scheduler emits a start or timeout pulse.
module tb_ce_task_scheduler;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ce = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] done;
  logic       clr = 1'b0;
  logic [2:0] start;
  logic [1:0] grant_idx;
  logic       busy;
  logic       timeout;
  logic       overrun;

  int compared = 0;
  int mismatched = 0;
  int start_q[$];
  int timeout_q[$];
  int done_delay = -1;
  logic [2:0] done_noise = 3'b000;

  ce_task_scheduler #(
    .par_num_tasks     (3),
    .par_tick_divisor  (4),
    .par_timeout_ticks (2)
  ) dut (
    .i_clk_mhz     (clk),
    .i_rstn_mhz    (rstn),
    .i_ce_mhz      (ce),
    .i_req         (req),
    .i_done        (done),
    .i_clr_overrun (clr),
    .o_start       (start),
    .o_grant_idx   (grant_idx),
    .o_busy        (busy),
    .o_timeout     (timeout),
    .o_overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitBusy(input logic level, input string name);
    int n;
    n = 0;
    while (busy !== level && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== level) checkOutput(name, 32'(busy), 32'(level));
  endtask

  // Emulated tasks: answer each start with a done pulse after done_delay clocks.
  initial begin
    int countdown;
    int idx;
    countdown = 0;
    idx = 0;
    done = 3'b000;
    forever begin
      @(negedge clk);
      done = done_noise;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) done[idx] = 1'b1;
      end
      if (start != 3'b000 && done_delay > 0) begin
        countdown = done_delay;
        for (int i = 0; i < 3; i++) if (start[i]) idx = i;
      end
    end
  end

  initial begin
    int cyc;
    int last_start_cyc;
    int exp_idx;
    cyc = 0;
    last_start_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (start != 3'b000) begin
        last_start_cyc = cyc;
        if (start_q.size() == 0) begin
          checkOutput("unexpected_start", 32'(start), 32'd0);
        end else begin
          exp_idx = start_q.pop_front();
          checkOutput("start_vector", 32'(start), 32'd1 << exp_idx);
          checkOutput("grant_idx", 32'(grant_idx), 32'(exp_idx));
        end
      end
      if (timeout) begin
        if (timeout_q.size() == 0) begin
          checkOutput("unexpected_timeout", 32'(timeout), 32'd0);
        end else begin
          exp_idx = timeout_q.pop_front();
          checkOutput("timeout_grant", 32'(grant_idx), 32'(exp_idx));
          checkOutput("timeout_latency", 32'(cyc - last_start_cyc), 32'd6);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] pattern, input int captures,
                               input int delay, input logic [2:0] noise);
    done_delay = delay;
    done_noise = noise;
    req = pattern;
    for (int c = 0; c < captures; c++) begin
      waitBusy(1'b0, "idle_before_capture");
      waitBusy(1'b1, "capture");
    end
    req = 3'b000;
    waitBusy(1'b0, "return_idle");
    done_noise = 3'b000;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start"}, 32'(start), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grant_idx), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstn = 1'b1;

    // 101 over two captures, done 5 clocks after start lands on the expiring tick
    start_q.push_back(0); start_q.push_back(2);
    start_q.push_back(0); start_q.push_back(2);
    applyStimulus(3'b101, 2, 5, 3'b000);
    checkOutput("s1_starts_served", 32'(start_q.size()), 32'd0);
    checkOutput("s1_last_grant", 32'(grant_idx), 32'd2);

    checkOutput("overrun_set", 32'(overrun), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checkOutput("overrun_cleared", 32'(overrun), 32'd0);

    start_q.push_back(0); start_q.push_back(1); start_q.push_back(2);
    start_q.push_back(0); start_q.push_back(1); start_q.push_back(2);
    applyStimulus(3'b111, 2, 1, 3'b000);
    checkOutput("s2_starts_served", 32'(start_q.size()), 32'd0);

    // No done for the granted task; done on the other lines must be ignored
    start_q.push_back(1);
    timeout_q.push_back(1);
    applyStimulus(3'b010, 1, -1, 3'b101);
    checkOutput("s3_starts_served", 32'(start_q.size()), 32'd0);
    checkOutput("s3_timeouts_seen", 32'(timeout_q.size()), 32'd0);
    checkOutput("s3_idle", 32'(busy), 32'd0);

    // Pointer left at 2 by the timeout, so 011 wraps to task 0 first
    start_q.push_back(0); start_q.push_back(1);
    applyStimulus(3'b011, 1, 1, 3'b000);
    checkOutput("s4_starts_served", 32'(start_q.size()), 32'd0);

    done_delay = -1;
    start_q.push_back(0);
    req = 3'b001;
    waitBusy(1'b1, "s5_capture");
    req = 3'b000;
    n = 0;
    while (start_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("s5_start_seen", 32'(start_q.size()), 32'd0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checkAllZero("midgrant_reset");
    repeat (2) @(negedge clk);
    done_delay = 1;
    start_q.push_back(2);
    req = 3'b100;
    rstn = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (start == 3'b000 && n < 40);
    checkOutput("first_start_not_early", 32'(n >= 7), 32'd1);
    checkOutput("first_start_not_late", 32'(n <= 11), 32'd1);
    req = 3'b000;
    waitBusy(1'b0, "s5_return_idle");
    repeat (4) @(negedge clk);
    checkOutput("final_starts_served", 32'(start_q.size()), 32'd0);
    checkOutput("final_timeouts_seen", 32'(timeout_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ce_task_scheduler.md
CE_TASK_SCHEDULER -- requirements
Module: ce_task_scheduler

Interface
REQ-001 SHALL have parameter par_num_tasks, default 3: number of requesters, range 2..8.
REQ-002 SHALL have parameter par_tick_divisor, default 1000: i_ce_mhz pulses per schedule tick.
REQ-003 SHALL have parameter par_timeout_ticks, default 4: schedule ticks allowed per granted task before abort.
REQ-004 SHALL have port i_clk_mhz, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rstn_mhz, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port i_ce_mhz, input, 1 bit: source clock enable.
REQ-007 SHALL have port i_req, input, par_num_tasks bits: level request per task.
REQ-008 SHALL have port i_done, input, par_num_tasks bits: one-cycle completion pulse per task.
REQ-009 SHALL have port i_clr_overrun, input, 1 bit: clears o_overrun.
REQ-010 SHALL have port o_start, output, par_num_tasks bits: one-cycle start pulse per task.
REQ-011 SHALL have port o_grant_idx, output, $clog2(par_num_tasks) bits: index of the current or last granted task.
REQ-012 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port o_timeout, output, 1 bit: one-cycle pulse when a grant aborts.
REQ-014 SHALL have port o_overrun, output, 1 bit: sticky flag, set when a tick arrives while not IDLE.

Function
REQ-015 SHALL derive an internal tick that is one clock high every par_tick_divisor i_ce_mhz pulses.
REQ-016 SHALL implement states IDLE, LATCH, START, WAIT_DONE.
REQ-017 In IDLE, a tick SHALL capture i_req into a pending mask and move to LATCH; with no tick, stay in IDLE.
REQ-018 In LATCH, an empty pending mask SHALL return to IDLE.
REQ-019 In LATCH, a non-empty mask SHALL select the first set bit at or after the round-robin pointer, wrapping modulo par_num_tasks, drive o_grant_idx, and move to START.
REQ-020 In START, o_start[grant] SHALL be high for exactly one clock; the state then moves to WAIT_DONE and the timeout counter clears.
REQ-021 In WAIT_DONE, i_done[grant] SHALL clear pending[grant], set the pointer to grant+1 (wrapping), and return to LATCH.
REQ-022 In WAIT_DONE, i_done bits other than grant SHALL be ignored.
REQ-023 In WAIT_DONE, the timeout counter SHALL increment on each tick.
REQ-024 When the counter reaches par_timeout_ticks without done, the scheduler SHALL pulse o_timeout, clear pending[grant], advance the pointer, and return to LATCH.
REQ-025 If i_done[grant] and the timeout-reaching tick occur in the same clock, done SHALL win and o_timeout SHALL stay low.
REQ-026 A tick in any state other than IDLE SHALL set o_overrun and SHALL NOT modify the pending mask.
REQ-027 i_clr_overrun SHALL clear o_overrun; a simultaneous set SHALL win.
REQ-028 Deassertion of i_req after capture SHALL NOT cancel a pending task.
REQ-029 Latency from tick to the first o_start SHALL be 3 clocks (IDLE→LATCH→START, pulse registered).
REQ-030 o_start SHALL be one-hot or zero at all times.

Reset
REQ-031 While i_rstn_mhz is low at a clock edge: state IDLE, pending mask 0, pointer 0, o_start 0, o_grant_idx 0, o_busy 0, o_timeout 0, o_overrun 0, and tick divider restarted.
REQ-032 Reset asserted mid-grant SHALL abort without an o_timeout pulse.
REQ-033 The first tick after reset release SHALL occur par_tick_divisor i_ce_mhz pulses later.

Structure
REQ-034 A shared package SHALL hold the state enum typedef and the grant-index width function.
REQ-035 The tick SHALL come from one instance of the existing clock_enable_divider, parameterised with par_ce_divisor = par_tick_divisor and reset driven by the inverse of i_rstn_mhz.
REQ-036 All other logic SHALL be local to this module.

Verification (par_num_tasks=3, par_tick_divisor=4, par_timeout_ticks=2, i_ce_mhz tied high)
REQ-037 i_req=3'b101 held, done returned 5 clocks after each start -> o_start[0], then o_start[2], per tick; pointer ends at 0.
REQ-038 i_req=3'b111 over two ticks, all done promptly -> grant order 0,1,2 then 0,1,2.
REQ-039 i_req=3'b010, done never returned -> o_timeout pulse 2 ticks after o_start[1], then IDLE.
REQ-040 Task held busy across 1 tick -> o_overrun=1; i_clr_overrun pulse -> 0.
REQ-041 Done and timeout-reaching tick in the same clock -> o_timeout=0, normal advance.
REQ-042 Reset low during WAIT_DONE -> next clock all outputs 0, first o_start after release no earlier than 4+3 clocks.
